dmem_bus_if: RTL and testbench

Data-memory bus interface for the ARM processor. It sits directly downstream of the datapath: it consumes the ALU result (as address), the store data, and the memory-write control, and it returns load data. Each load or store becomes a single req/ack transaction on an external word-wide bus. While the transaction is outstanding, `Stall` holds the processor (PC register and register-file write enables are gated by the top level).

---
 rtl/dmem_bus_if.sv | 123 ++++++++++++
 tb/tb_dmem_bus_if.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bus_if.sv
// dmem_bus_if: data-memory bus interface between the ARM datapath and a
// word-wide req/ack bus. Every load or store becomes one bus transaction.
// Stall holds the processor until the access reaches DONE.
//
// Optional feature macro: DMEM_TIMEOUT_EN
//   defined   -> REQ wait counter and watchdog compiled in (TIMEOUT cycles)
//   undefined -> REQ waits for BusAck indefinitely
//
// Handshake: BusReq is raised in the first REQ cycle and held, together with
// BusWe/BusAddr/BusWData, until the cycle after BusAck is sampled high
// (or the watchdog fires). BusAck is a one-cycle pulse and is ignored
// outside REQ. BusRData is only looked at in the cycle BusAck is high.
module dmem_bus_if #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemEn,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        MemFault,
  output logic        BusReq,
  output logic        BusWe,
  output logic [31:0] BusAddr,
  output logic [31:0] BusWData,
  input  logic [31:0] BusRData,
  input  logic        BusAck,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;

`ifdef DMEM_TIMEOUT_EN
  // Last REQ cycle index the watchdog tolerates before aborting.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wait_cnt;
`else
  // Without the watchdog the timeout parameter has no effect.
  logic unused_timeout;
  assign unused_timeout = ^8'(TIMEOUT);
`endif

  // The processor may advance only in DONE, or when no memory op is present.
  assign Stall     = MemEn & (state != S_DONE);
  assign state_dbg = state;

  // Access sequencer: IDLE -> REQ -> DONE (or IDLE -> DONE on misalignment).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      ReadData <= 32'h0;
      BusAddr  <= 32'h0;
      BusWData <= 32'h0;
      BusReq   <= 1'b0;
      BusWe    <= 1'b0;
      MemFault <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
      wait_cnt <= 8'h0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (MemEn) begin
            if (Addr[1:0] == 2'b00) begin
              BusReq   <= 1'b1;
              BusWe    <= MemWrite;
              BusAddr  <= Addr;
              BusWData <= WriteData;
              state    <= S_REQ;
`ifdef DMEM_TIMEOUT_EN
              wait_cnt <= 8'h0;
`endif
            end else begin
              // Misaligned: no bus traffic, flag the fault and return zero.
              MemFault <= 1'b1;
              ReadData <= 32'h0;
              state    <= S_DONE;
            end
          end
        end
        S_REQ: begin
          if (BusAck) begin
            // Ack beats a simultaneous watchdog expiry.
            if (!BusWe) begin
              ReadData <= BusRData;
            end
            BusReq <= 1'b0;
            state  <= S_DONE;
          end
`ifdef DMEM_TIMEOUT_EN
          else if (wait_cnt == WAIT_LAST) begin
            BusReq   <= 1'b0;
            MemFault <= 1'b1;
            if (!BusWe) begin
              ReadData <= 32'h0;
            end
            state <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'h1;
          end
`endif
        end
        S_DONE: begin
          // Always pass through IDLE so back-to-back ops start afresh.
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bus_if.sv
// Testbench for dmem_bus_if. Inputs change 1 time unit after the rising
// edge, outputs are sampled on the falling edge. A transaction-level model
// predicts latency, bus occupancy, ReadData and MemFault for every access.
module tb_dmem_bus_if;

`ifdef DMEM_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif

  logic        clk;
  logic        reset;
  logic        mem_en;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        stall;
  logic        mem_fault;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic [1:0]  state_dbg;

  int n_cmp;
  int n_fail;

  // Measurements of the most recent access
  int          m_stall;
  int          m_req;
  logic [31:0] m_rd;
  logic        m_flt;
  bit          m_stable;
  logic        m_req_done;

  // Reference model state and predictions
  logic [31:0] ref_rd;
  logic        ref_fault;
  int          exp_stall;
  int          exp_req;
  logic [31:0] exp_q[$];

  dmem_bus_if #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemEn     (mem_en),
    .MemWrite  (mem_write),
    .Addr      (addr),
    .WriteData (write_data),
    .ReadData  (read_data),
    .Stall     (stall),
    .MemFault  (mem_fault),
    .BusReq    (bus_req),
    .BusWe     (bus_we),
    .BusAddr   (bus_addr),
    .BusWData  (bus_wdata),
    .BusRData  (bus_rdata),
    .BusAck    (bus_ack),
    .state_dbg (state_dbg)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Transaction-level prediction: an aligned access with an ack in REQ
  // cycle n costs 1 + n stalled cycles; a watchdog abort costs 1 + TIMEOUT;
  // a misaligned access costs 1 stalled cycle and never touches the bus.
  task automatic model_access(input logic we, input logic [31:0] a, input int n_ack,
                              input logic [31:0] rd);
    bit timed_out;
    timed_out = 1'b0;
`ifdef DMEM_TIMEOUT_EN
    timed_out = (n_ack == 0) || (n_ack > TO);
`endif
    if (a[1:0] != 2'b00) begin
      exp_stall = 1;
      exp_req   = 0;
      ref_fault = 1'b1;
      ref_rd    = 32'h0;
    end else if (timed_out) begin
      exp_stall = 1 + TO;
      exp_req   = TO;
      ref_fault = 1'b1;
      if (!we) ref_rd = 32'h0;
    end else begin
      exp_stall = 1 + n_ack;
      exp_req   = n_ack;
      if (!we) ref_rd = rd;
    end
    exp_q.push_back(ref_rd);
  endtask

  // Driver: must be entered just after a rising edge with the DUT in IDLE.
  // Acks in REQ cycle n_ack (0 = never ack). Leaves MemEn high if keep_en.
  task automatic run_access(input logic we, input logic [31:0] a, input logic [31:0] d,
                            input int n_ack, input logic [31:0] rd, input bit keep_en);
    bit done;
    model_access(we, a, n_ack, rd);
    mem_en     = 1'b1;
    mem_write  = we;
    addr       = a;
    write_data = d;
    bus_ack    = 1'b0;
    m_stall    = 0;
    m_req      = 0;
    m_stable   = 1'b1;
    m_req_done = 1'b0;
    done       = 1'b0;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      @(negedge clk);
      if (stall) m_stall++;
      if (!stall) begin
        m_rd       = read_data;
        m_flt      = mem_fault;
        m_req_done = bus_req;
        done       = 1'b1;
      end else if (bus_req) begin
        m_req++;
        if (bus_addr !== a || bus_we !== we || (we && bus_wdata !== d)) m_stable = 1'b0;
        if (m_req == n_ack) begin
          bus_ack   = 1'b1;
          bus_rdata = rd;
        end
      end
      @(posedge clk);
      #1;
      bus_ack   = 1'b0;
      bus_rdata = $urandom;
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL access_bound: DONE not reached within 100 cycles, required completion");
    end
    if (!keep_en) mem_en = 1'b0;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    mem_en     = 1'b0;
    mem_write  = 1'b0;
    addr       = 32'h0;
    write_data = 32'h0;
    bus_rdata  = 32'h0;
    bus_ack    = 1'b0;
    ref_rd     = 32'h0;
    ref_fault  = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({read_data, bus_addr, bus_wdata, bus_req, bus_we, mem_fault, stall} !== 100'h0) begin
      n_fail++;
      $display("FAIL reset_values: got rd=%h ba=%h bw=%h req=%b we=%b flt=%b stall=%b, required all 0",
               read_data, bus_addr, bus_wdata, bus_req, bus_we, mem_fault, stall);
    end
    mem_en = 1'b1;
    #1;
    n_cmp++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_stall_follows_memen: got %b required 1", stall);
    end
    mem_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_load_immediate();
    run_access(1'b0, 32'h100, 32'h0, 1, 32'hCAFEF00D, 1'b0);
    n_cmp++;
    if (m_stall !== exp_stall || m_stall !== 2) begin
      n_fail++;
      $display("FAIL load_imm_stall: got %0d cycles required %0d", m_stall, exp_stall);
    end
    n_cmp++;
    if (m_req !== exp_req || m_stable !== 1'b1) begin
      n_fail++;
      $display("FAIL load_imm_bus: got req_cycles=%0d stable=%b required %0d/1", m_req, m_stable, exp_req);
    end
    n_cmp++;
    if (m_rd !== exp_q.pop_front()) begin
      n_fail++;
      $display("FAIL load_imm_data: got %h required %h", m_rd, ref_rd);
    end
  endtask

  task automatic test_store_wait();
    logic [31:0] exp_rd;
    run_access(1'b1, 32'h20, 32'h12345678, 5, $urandom, 1'b0);
    exp_rd = exp_q.pop_front();
    n_cmp++;
    if (m_stall !== exp_stall || m_req !== exp_req) begin
      n_fail++;
      $display("FAIL store_wait_timing: got stall=%0d req=%0d required %0d/%0d",
               m_stall, m_req, exp_stall, exp_req);
    end
    n_cmp++;
    if (m_stable !== 1'b1) begin
      n_fail++;
      $display("FAIL store_wait_stable: got stable=%b required 1", m_stable);
    end
    n_cmp++;
    if (m_rd !== exp_rd || m_flt !== ref_fault) begin
      n_fail++;
      $display("FAIL store_wait_rd: got rd=%h flt=%b required %h/%b", m_rd, m_flt, exp_rd, ref_fault);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    d = $urandom;
    run_access(1'b0, 32'h200, 32'h0, 1, d, 1'b1);
    n_cmp++;
    if (m_stall !== exp_stall || m_rd !== exp_q.pop_front() || m_req_done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_load: got stall=%0d rd=%h req_in_done=%b required %0d/%h/0",
               m_stall, m_rd, m_req_done, exp_stall, ref_rd);
    end
    run_access(1'b1, 32'h204, 32'hA5A5_0F0F, 1, $urandom, 1'b0);
    n_cmp++;
    if (m_stall !== exp_stall || m_req !== exp_req || m_stable !== 1'b1 || m_rd !== exp_q.pop_front()) begin
      n_fail++;
      $display("FAIL b2b_store: got stall=%0d req=%0d stable=%b rd=%h required %0d/%0d/1/%h",
               m_stall, m_req, m_stable, m_rd, exp_stall, exp_req, ref_rd);
    end
  endtask

  task automatic test_misaligned();
    run_access(1'b0, 32'h102, 32'h0, 1, $urandom, 1'b0);
    n_cmp++;
    if (m_stall !== 1 || m_req !== 0) begin
      n_fail++;
      $display("FAIL misaligned_timing: got stall=%0d req=%0d required 1/0", m_stall, m_req);
    end
    n_cmp++;
    if (m_flt !== 1'b1 || m_rd !== exp_q.pop_front()) begin
      n_fail++;
      $display("FAIL misaligned_result: got flt=%b rd=%h required 1/%h", m_flt, m_rd, ref_rd);
    end
  endtask

`ifdef DMEM_TIMEOUT_EN
  task automatic test_timeout();
    // Ack arriving in the last tolerated REQ cycle wins; fault stays clear.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ref_rd = 32'h0;
    ref_fault = 1'b0;
    @(posedge clk);
    #1;
    run_access(1'b0, 32'h300, 32'h0, TO, 32'h600DF00D, 1'b0);
    n_cmp++;
    if (m_flt !== 1'b0 || m_rd !== exp_q.pop_front() || m_req !== TO) begin
      n_fail++;
      $display("FAIL timeout_ack_wins: got flt=%b rd=%h req=%0d required 0/%h/%0d", m_flt, m_rd, m_req, ref_rd, TO);
    end
    run_access(1'b0, 32'h304, 32'h0, 0, 32'h0, 1'b0);
    n_cmp++;
    if (m_req !== TO || m_stall !== TO + 1 || m_flt !== 1'b1 || m_rd !== exp_q.pop_front()) begin
      n_fail++;
      $display("FAIL timeout_abort: got req=%0d stall=%0d flt=%b rd=%h required %0d/%0d/1/%h",
               m_req, m_stall, m_flt, m_rd, TO, TO + 1, ref_rd);
    end
  endtask
`endif

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] exp_rd;
    logic        we;
    int          n;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      we = $urandom_range(0, 1);
`ifdef DMEM_TIMEOUT_EN
      n = $urandom_range(0, 6);
`else
      n = $urandom_range(1, 6);
`endif
      run_access(we, a, $urandom, n, $urandom, $urandom_range(0, 1));
      exp_rd = exp_q.pop_front();
      n_cmp++;
      if (m_stall !== exp_stall || m_req !== exp_req || m_stable !== 1'b1 ||
          m_rd !== exp_rd || m_flt !== ref_fault) begin
        n_fail++;
        $display("FAIL random[%0d] a=%h we=%b n=%0d: got stall=%0d req=%0d stable=%b rd=%h flt=%b required %0d/%0d/1/%h/%b",
                 i, a, we, n, m_stall, m_req, m_stable, m_rd, m_flt, exp_stall, exp_req, exp_rd, ref_fault);
      end
      if (!mem_en) begin
        // Idle cycle with a stray ack: nothing may move.
        bus_ack = 1'b1;
        bus_rdata = $urandom;
        @(negedge clk);
        n_cmp++;
        if (stall !== 1'b0 || bus_req !== 1'b0) begin
          n_fail++;
          $display("FAIL idle_gap: got stall=%b req=%b required 0/0", stall, bus_req);
        end
        @(posedge clk);
        #1;
        bus_ack = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (read_data !== ref_rd) begin
          n_fail++;
          $display("FAIL stray_ack: got rd=%h required %h", read_data, ref_rd);
        end
        @(posedge clk);
        #1;
      end
    end
    mem_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_req();
    int cnt;
    run_access(1'b0, 32'h40, 32'h0, 1, 32'hDEAD_BEEF, 1'b0);
    void'(exp_q.pop_front());
    mem_en    = 1'b1;
    mem_write = 1'b0;
    addr      = 32'h48;
    bus_ack   = 1'b0;
    cnt = 0;
    for (int c = 0; c < 10 && cnt < 2; c++) begin
      @(negedge clk);
      if (bus_req) cnt++;
      if (cnt < 2) begin
        @(posedge clk);
        #1;
      end
    end
    n_cmp++;
    if (cnt !== 2) begin
      n_fail++;
      $display("FAIL mid_req_reach: got %0d REQ cycles required 2", cnt);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus_req !== 1'b0 || bus_we !== 1'b0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_req_bus_drop: got req=%b we=%b ba=%h bw=%h required all 0",
               bus_req, bus_we, bus_addr, bus_wdata);
    end
    n_cmp++;
    if (read_data !== 32'h0 || mem_fault !== 1'b0 || stall !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_req_outputs: got rd=%h flt=%b stall=%b required 0/0/1", read_data, mem_fault, stall);
    end
    mem_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    ref_rd = 32'h0;
    ref_fault = 1'b0;
    @(posedge clk);
    #1;
    run_access(1'b0, 32'h4C, 32'h0, 2, 32'h1357_9BDF, 1'b0);
    n_cmp++;
    if (m_stall !== exp_stall || m_rd !== exp_q.pop_front() || m_flt !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset_access: got stall=%0d rd=%h flt=%b required %0d/%h/0",
               m_stall, m_rd, m_flt, exp_stall, ref_rd);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_load_immediate();
    test_store_wait();
    test_back_to_back();
    test_random();
    test_misaligned();
`ifdef DMEM_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
